// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW hazard detection and EX operand selection.
// Build option: define FWD_EN for the MEM/WB forwarding network; otherwise RAW hazards stall.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_aluc,
  input  logic              id_src_a_pc,
  input  logic              id_src_b_imm,
  input  logic              id_reg_we,
  input  logic              id_mem_re,
  input  logic              id_mem_we,
  input  logic              id_is_branch,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_we,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_we,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [4:0]        alu_op,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_we,
  output logic              ex_mem_re,
  output logic              ex_mem_we,
  output logic              ex_is_branch,
  output logic              hazard_stall
);

  logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
  logic [REG_AW-1:0] rs1_q, rs2_q;
  logic              src_a_pc_q, src_b_imm_q;
  logic [XLEN-1:0]   fwd_rs1, fwd_rs2;
  logic              raw_hazard, bubble;

  logic load_use;
  assign load_use = ex_valid & ex_mem_re & (ex_rd != '0) & id_valid &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

`ifdef FWD_EN
  always_comb begin
    fwd_rs1 = rs1_data_q;
    fwd_rs2 = rs2_data_q;
    if (mem_reg_we && (mem_rd != '0) && (mem_rd == rs1_q))    fwd_rs1 = mem_result;
    else if (wb_reg_we && (wb_rd != '0) && (wb_rd == rs1_q))  fwd_rs1 = wb_result;
    if (mem_reg_we && (mem_rd != '0) && (mem_rd == rs2_q))    fwd_rs2 = mem_result;
    else if (wb_reg_we && (wb_rd != '0) && (wb_rd == rs2_q))  fwd_rs2 = wb_result;
  end

  assign raw_hazard = load_use;
`else
  // WB producers need no stall: the register file writes through to the ID read.
  logic ex_raw, mem_raw;
  assign ex_raw  = ex_valid & ex_reg_we & (ex_rd != '0) &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign mem_raw = mem_reg_we & (mem_rd != '0) &
                   ((mem_rd == id_rs1) | (mem_rd == id_rs2));

  assign fwd_rs1    = rs1_data_q;
  assign fwd_rs2    = rs2_data_q;
  assign raw_hazard = load_use | ex_raw | mem_raw;

  logic unused_fwd;
  assign unused_fwd = ^{mem_result, wb_rd, wb_reg_we, wb_result, rs1_q, rs2_q};
`endif

  assign hazard_stall  = raw_hazard & ~flush;
  assign alu_a         = src_a_pc_q  ? ex_pc : fwd_rs1;
  assign alu_b         = src_b_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

  assign bubble = flush | hazard_stall | ~id_valid;

  // Data fields load even on a bubble; only the control fields are forced to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      ex_rd        <= '0;
      alu_op       <= '0;
      src_a_pc_q   <= 1'b0;
      src_b_imm_q  <= 1'b0;
      ex_reg_we    <= 1'b0;
      ex_mem_re    <= 1'b0;
      ex_mem_we    <= 1'b0;
      ex_is_branch <= 1'b0;
    end else if (flush || !stall) begin
      ex_pc       <= id_pc;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      ex_rd       <= id_rd;
      src_a_pc_q  <= id_src_a_pc;
      src_b_imm_q <= id_src_b_imm;
      if (bubble) begin
        ex_valid     <= 1'b0;
        alu_op       <= '0;
        ex_reg_we    <= 1'b0;
        ex_mem_re    <= 1'b0;
        ex_mem_we    <= 1'b0;
        ex_is_branch <= 1'b0;
      end else begin
        ex_valid     <= 1'b1;
        alu_op       <= id_aluc;
        ex_reg_we    <= id_reg_we;
        ex_mem_re    <= id_mem_re;
        ex_mem_we    <= id_mem_we;
        ex_is_branch <= id_is_branch;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; expectations follow the FWD_EN build setting.
module tb_id_ex_stage;

`ifdef FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst_n, stall, flush;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_aluc;
  logic        id_src_a_pc, id_src_b_imm, id_reg_we, id_mem_re, id_mem_we, id_is_branch;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_we, wb_reg_we;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [31:0] ex_pc, alu_a, alu_b, ex_store_data;
  logic [4:0]  alu_op, ex_rd;
  logic        ex_reg_we, ex_mem_re, ex_mem_we, ex_is_branch, hazard_stall;

  int n_checks = 0;
  int n_errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_aluc(id_aluc), .id_src_a_pc(id_src_a_pc),
    .id_src_b_imm(id_src_b_imm), .id_reg_we(id_reg_we), .id_mem_re(id_mem_re),
    .id_mem_we(id_mem_we), .id_is_branch(id_is_branch),
    .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_we(wb_reg_we), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_is_branch(ex_is_branch), .hazard_stall(hazard_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, r1d, r2d, imm,
                          input logic [4:0] r1, r2, rd, op,
                          input logic sa, sb, we, re, mwe, br);
    id_valid = v;  id_pc = pc;  id_rs1_data = r1d;  id_rs2_data = r2d;  id_imm = imm;
    id_rs1 = r1;  id_rs2 = r2;  id_rd = rd;  id_aluc = op;
    id_src_a_pc = sa;  id_src_b_imm = sb;
    id_reg_we = we;  id_mem_re = re;  id_mem_we = mwe;  id_is_branch = br;
  endtask

  task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_we = mwe;  mem_rd = mrd;  mem_result = mres;
    wb_reg_we = wwe;   wb_rd = wrd;   wb_result = wres;
  endtask

  initial begin
    rst_n = 1'b0;  stall = 1'b0;  flush = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    #12;
    check("rst_valid", {31'd0, ex_valid}, 0);
    check("rst_alu_op", {27'd0, alu_op}, 0);
    check("rst_pc", ex_pc, 0);
    check("rst_rd", {27'd0, ex_rd}, 0);
    check("rst_hazard", {31'd0, hazard_stall}, 0);
    rst_n = 1'b1;

    // Plain register-register add: one-cycle latency, rs1/rs2 on a/b.
    @(negedge clk);
    drive_id(1, 32'h100, 32'hA, 32'h3, 32'h0, 1, 2, 4, 5'd1, 0, 0, 1, 0, 0, 0);
    tick();
    check("add_valid", {31'd0, ex_valid}, 1);
    check("add_pc", ex_pc, 32'h100);
    check("add_a", alu_a, 32'hA);
    check("add_b", alu_b, 32'h3);
    check("add_op", {27'd0, alu_op}, 1);
    check("add_rd", {27'd0, ex_rd}, 4);
    check("add_we", {31'd0, ex_reg_we}, 1);

    // PC / immediate source select; store data still follows rs2.
    drive_id(1, 32'h200, 32'hB, 32'h7, 32'h44, 1, 2, 4, 5'd2, 1, 1, 1, 0, 0, 0);
    tick();
    check("sel_a_pc", alu_a, 32'h200);
    check("sel_b_imm", alu_b, 32'h44);
    check("sel_store", ex_store_data, 32'h7);

    // MEM over WB forwarding priority on rs1 and rs2 = x5.
    drive_id(1, 32'h204, 32'h99, 32'h77, 32'h0, 5, 5, 6, 5'd1, 0, 0, 1, 0, 0, 0);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(1, 5, 32'h11, 1, 5, 32'h22);
    #1;
    check("fwd_mem_a", alu_a, FWD ? 32'h11 : 32'h99);
    check("fwd_mem_b", alu_b, FWD ? 32'h11 : 32'h77);
    check("fwd_mem_st", ex_store_data, FWD ? 32'h11 : 32'h77);
    mem_reg_we = 1'b0;
    #1;
    check("fwd_wb_a", alu_a, FWD ? 32'h22 : 32'h99);
    wb_reg_we = 1'b0;
    #1;
    check("fwd_none_a", alu_a, 32'h99);

    // x0 is never forwarded.
    drive_id(1, 32'h208, 32'h0, 32'h0, 32'h0, 0, 0, 6, 5'd1, 0, 0, 1, 0, 1, 0);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_fwd(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    #1;
    check("x0_b", alu_b, 0);
    check("x0_store", ex_store_data, 0);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Load-use: lw x7 in EX, add x9, x7, x8 in ID.
    drive_id(1, 32'h300, 32'h0, 32'h0, 32'h0, 1, 2, 7, 5'd1, 0, 1, 1, 1, 0, 0);
    tick();
    drive_id(1, 32'h304, 32'h0, 32'h8, 32'h0, 7, 8, 9, 5'd1, 0, 0, 1, 0, 0, 0);
    #1;
    check("lu_hazard", {31'd0, hazard_stall}, 1);
    tick();
    check("lu_bubble", {31'd0, ex_valid}, 0);
    check("lu_bubble_we", {31'd0, ex_reg_we}, 0);
    set_fwd(1, 7, 32'h55, 0, 0, 0);
    #1;
    check("lu_hazard2", {31'd0, hazard_stall}, FWD ? 1'b0 : 1'b1);
    tick();
    check("lu_add_valid", {31'd0, ex_valid}, FWD ? 1'b1 : 1'b0);
    check("lu_add_a", alu_a, FWD ? 32'h55 : 32'h0);
    set_fwd(0, 0, 0, 1, 7, 32'h55);
    id_rs1_data = 32'h55;
    #1;
    check("lu_hazard3", {31'd0, hazard_stall}, 0);
    tick();
    check("lu_final_valid", {31'd0, ex_valid}, 1);
    check("lu_final_a", alu_a, 32'h55);
    set_fwd(0, 0, 0, 0, 0, 0);

    // Flush and stall on the same edge: flush wins.
    drive_id(1, 32'h400, 32'h1, 32'h2, 32'h0, 1, 2, 0, 5'd3, 0, 1, 0, 0, 1, 0);
    tick();
    check("st_mem_we", {31'd0, ex_mem_we}, 1);
    stall = 1'b1;  flush = 1'b1;
    tick();
    check("fs_valid", {31'd0, ex_valid}, 0);
    check("fs_mem_we", {31'd0, ex_mem_we}, 0);
    stall = 1'b0;  flush = 1'b0;

    // Stall alone holds every output for three cycles.
    drive_id(1, 32'h500, 32'h1, 32'h2, 32'h0, 1, 2, 5, 5'd2, 0, 0, 1, 0, 0, 1);
    tick();
    stall = 1'b1;
    drive_id(0, 32'h600, 32'h3, 32'h4, 32'h0, 1, 2, 6, 5'd3, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_pc", ex_pc, 32'h500);
      check("hold_op", {27'd0, alu_op}, 2);
      check("hold_valid", {31'd0, ex_valid}, 1);
      check("hold_branch", {31'd0, ex_is_branch}, 1);
    end
    stall = 1'b0;

    // Flush gates the load-use hazard.
    drive_id(1, 32'h700, 32'h0, 32'h0, 32'h0, 1, 2, 7, 5'd1, 0, 1, 1, 1, 0, 0);
    tick();
    drive_id(1, 32'h704, 32'h0, 32'h0, 32'h0, 7, 8, 9, 5'd1, 0, 0, 1, 0, 0, 0);
    flush = 1'b1;
    #1;
    check("flush_hazard", {31'd0, hazard_stall}, 0);
    tick();
    check("flush_bubble", {31'd0, ex_valid}, 0);
    flush = 1'b0;

    // add x3 in EX, dependent on rs2 in ID.
    drive_id(1, 32'h800, 32'h0, 32'h0, 32'h0, 1, 2, 3, 5'd1, 0, 0, 1, 0, 0, 0);
    tick();
    drive_id(1, 32'h804, 32'h0, 32'h5, 32'h0, 0, 3, 10, 5'd1, 0, 0, 1, 0, 0, 0);
    #1;
    check("raw_hazard", {31'd0, hazard_stall}, FWD ? 1'b0 : 1'b1);
    tick();
    set_fwd(1, 3, 32'h33, 0, 0, 0);
    #1;
    check("raw_hazard2", {31'd0, hazard_stall}, FWD ? 1'b0 : 1'b1);
    check("raw_valid", {31'd0, ex_valid}, FWD ? 1'b1 : 1'b0);
    check("raw_b", alu_b, FWD ? 32'h33 : 32'h5);
    set_fwd(0, 0, 0, 0, 0, 0);
    #1;
    check("raw_clear", {31'd0, hazard_stall}, 0);

    // Asynchronous reset while a load-use hazard is pending.
    drive_id(1, 32'h900, 32'h0, 32'h0, 32'h0, 1, 2, 7, 5'd1, 0, 1, 1, 1, 0, 0);
    tick();
    drive_id(1, 32'h904, 32'h0, 32'h0, 32'h0, 7, 8, 9, 5'd1, 0, 0, 1, 0, 0, 0);
    #1;
    check("pre_rst_hazard", {31'd0, hazard_stall}, 1);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 0);
    check("arst_we", {31'd0, ex_reg_we}, 0);
    check("arst_op", {27'd0, alu_op}, 0);
    check("arst_hazard", {31'd0, hazard_stall}, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
